// File: rtl/reg_file_reader_pkg.sv
// Shared types and default sizing for the reg_file_reader burst-read register file.
package reg_file_reader_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int LEN_W_DEF  = ADDR_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/reg_file_reader_if.sv
// Write port, burst request and valid/ready stream of reg_file_reader.
// Optional parity output present when REG_FILE_READER_PARITY_EN is defined.
interface reg_file_reader_if
    import reg_file_reader_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              load;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  d;
    logic              start;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   len;
    logic [WIDTH-1:0]  out;
    logic              valid;
    logic              ready;
    logic              busy;
    logic              done;
`ifdef REG_FILE_READER_PARITY_EN
    logic              parity;

    modport master (
        output load, waddr, d, start, raddr, len, ready,
        input  out, valid, busy, done, parity
    );
    modport slave (
        input  load, waddr, d, start, raddr, len, ready,
        output out, valid, busy, done, parity
    );
`else
    modport master (
        output load, waddr, d, start, raddr, len, ready,
        input  out, valid, busy, done
    );
    modport slave (
        input  load, waddr, d, start, raddr, len, ready,
        output out, valid, busy, done
    );
`endif

endinterface

// File: rtl/reg_file_reader_reg_word.sv
// One load-enabled register word with synchronous active-high reset.
module reg_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = load ? d : q_q;
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/reg_file_reader.sv
// Register file with burst read engine streaming words over valid/ready.
// Optional even-parity output enabled by REG_FILE_READER_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for start; latches raddr/len and fetches first word
// SEND  | valid=1; each handshake advances ptr and fetches the next word
// DONE  | one-cycle done pulse, then back to IDLE
module reg_file_reader
    import reg_file_reader_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    reg_file_reader_if.slave  bus
);

    localparam int LEN_W = ADDR_W + 1;

    logic [WIDTH-1:0]  reg_q [DEPTH];
    logic [DEPTH-1:0]  wr_en;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            assign wr_en[gi] = bus.load && (bus.waddr == ADDR_W'(gi));
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .reset (reset),
                .load  (wr_en[gi]),
                .d     (bus.d),
                .q     (reg_q[gi])
            );
        end
    endgenerate

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic [LEN_W-1:0]  rem_q, rem_d, len_clamped;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Fetches read reg_q before this edge's write lands, so a same-edge write yields the old word.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        out_d       = out_q;
        valid_d     = valid_q;
        ptr_inc     = ptr_q + ADDR_W'(1);
        len_clamped = (bus.len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.len;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ptr_d = bus.raddr;
                    rem_d = len_clamped;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SEND;
                        out_d   = reg_q[bus.raddr];
                        valid_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (valid_q && bus.ready) begin
                    ptr_d = ptr_inc;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end else begin
                        out_d = reg_q[ptr_inc];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

`ifdef REG_FILE_READER_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = ^out_d;
    end

    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end

    assign bus.parity = parity_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_reg_file_reader.sv
// Directed self-checking bench for reg_file_reader (parity checks when REG_FILE_READER_PARITY_EN is defined).
module tb_reg_file_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    reg_file_reader_if bus ();

    reg_file_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] v);
        bus.load  = 1'b1;
        bus.waddr = a;
        bus.d     = v;
        step();
        bus.load  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_tests++; if (bus.out !== 16'd0) begin n_fail++; $display("FAIL reset_out got=%0h exp=0", bus.out); end
        n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] exp_w [3];
        exp_w = '{16'd20, 16'd111, 16'd1133};
        write_reg(3'd0, 16'd20);
        write_reg(3'd1, 16'd111);
        write_reg(3'd2, 16'd1133);
        bus.raddr = 3'd0; bus.len = 4'd3; bus.ready = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bus.out !== exp_w[k] || bus.valid !== 1'b1 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL basic_word%0d got=%0d v=%b b=%b exp=%0d v=1 b=1", k, bus.out, bus.valid, bus.busy, exp_w[k]);
            end
            step();
        end
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_done got d=%b b=%b v=%b exp d=1 b=1 v=0", bus.done, bus.busy, bus.valid);
        end
        step();
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle got d=%b b=%b exp d=0 b=0", bus.done, bus.busy);
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp_w [3];
        bit          pat [5];
        int          idx;
        logic [15:0] prev;
        exp_w = '{16'd20, 16'd111, 16'd1133};
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        idx   = 0;
        bus.raddr = 3'd0; bus.len = 4'd3; bus.ready = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_tests++;
        if (bus.out !== 16'd20 || bus.valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_first got=%0d v=%b exp=20 v=1", bus.out, bus.valid);
        end
        for (int i = 0; i < 5; i++) begin
            bus.ready = pat[i];
            prev = bus.out;
            step();
            if (pat[i]) idx++;
            n_tests++;
            if (!pat[i]) begin
                if (bus.out !== prev || bus.valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall_hold%0d got=%0d v=%b exp=%0d v=1", i, bus.out, bus.valid, prev);
                end
            end else if (idx < 3) begin
                if (bus.out !== exp_w[idx] || bus.valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall_word%0d got=%0d v=%b exp=%0d v=1", i, bus.out, bus.valid, exp_w[idx]);
                end
            end else begin
                if (bus.done !== 1'b1 || bus.valid !== 1'b0) begin
                    n_fail++; $display("FAIL stall_done got d=%b v=%b exp d=1 v=0", bus.done, bus.valid);
                end
            end
        end
        bus.ready = 1'b1;
        step();
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w [4];
        exp_w = '{16'd106, 16'd107, 16'd100, 16'd101};
        for (int i = 0; i < 8; i++) write_reg(3'(i), 16'(100 + i));
        bus.raddr = 3'd6; bus.len = 4'd4; bus.ready = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (bus.out !== exp_w[k] || bus.valid !== 1'b1) begin
                n_fail++; $display("FAIL wrap_word%0d got=%0d v=%b exp=%0d", k, bus.out, bus.valid, exp_w[k]);
            end
            step();
        end
        n_tests++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got=%b exp=1", bus.done); end
        step();
    endtask

    task automatic test_len_edges();
        bus.raddr = 3'd5; bus.len = 4'd0; bus.ready = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_tests++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL len0_done got v=%b d=%b b=%b exp v=0 d=1 b=1", bus.valid, bus.done, bus.busy);
        end
        step();
        n_tests++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL len0_idle got v=%b d=%b b=%b exp v=0 d=0 b=0", bus.valid, bus.done, bus.busy);
        end
        // len above DEPTH reads each word once
        bus.raddr = 3'd2; bus.len = 4'd15; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (bus.out !== 16'(100 + ((2 + k) % 8)) || bus.valid !== 1'b1) begin
                n_fail++; $display("FAIL clamp_word%0d got=%0d v=%b exp=%0d", k, bus.out, bus.valid, 100 + ((2 + k) % 8));
            end
            step();
        end
        n_tests++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0) begin
            n_fail++; $display("FAIL clamp_done got d=%b v=%b exp d=1 v=0", bus.done, bus.valid);
        end
        step();
    endtask

    task automatic test_start_busy();
        bus.raddr = 3'd0; bus.len = 4'd3; bus.ready = 1'b1; bus.start = 1'b1;
        step();
        bus.raddr = 3'd5; bus.len = 4'd1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bus.out !== 16'(100 + k) || bus.valid !== 1'b1) begin
                n_fail++; $display("FAIL busy_start_word%0d got=%0d v=%b exp=%0d", k, bus.out, bus.valid, 100 + k);
            end
            if (k == 2) bus.start = 1'b0;
            step();
        end
        n_tests++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL busy_start_done got=%b exp=1", bus.done); end
        step();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_idle got b=%b v=%b exp 0 0", bus.busy, bus.valid);
        end
    endtask

    task automatic test_write_during();
        logic [15:0] exp_w [5];
        exp_w = '{16'd100, 16'd101, 16'd102, 16'hBEEF, 16'd104};
        bus.raddr = 3'd0; bus.len = 4'd5; bus.ready = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (bus.out !== exp_w[k]) begin
                n_fail++; $display("FAIL wdur_word%0d got=%0h exp=%0h", k, bus.out, exp_w[k]);
            end
            bus.load = 1'b0;
            if (k == 0) begin bus.load = 1'b1; bus.waddr = 3'd3; bus.d = 16'hBEEF; end
            if (k == 1) begin bus.load = 1'b1; bus.waddr = 3'd2; bus.d = 16'h1234; end
            step();
        end
        bus.load = 1'b0;
        n_tests++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL wdur_done got=%b exp=1", bus.done); end
        step();
        bus.raddr = 3'd2; bus.len = 4'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_tests++;
        if (bus.out !== 16'h1234) begin n_fail++; $display("FAIL wdur_late got=%0h exp=1234", bus.out); end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        bus.raddr = 3'd0; bus.len = 4'd8; bus.ready = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        reset = 1'b1;
        step();
        n_tests++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_state got v=%b b=%b d=%b o=%0h exp 0 0 0 0", bus.valid, bus.busy, bus.done, bus.out);
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_nodone got d=%b b=%b exp 0 0", bus.done, bus.busy);
        end
        bus.raddr = 3'd0; bus.len = 4'd8; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (bus.out !== 16'd0 || bus.valid !== 1'b1) begin
                n_fail++; $display("FAIL rstmid_clear%0d got=%0h v=%b exp=0 v=1", k, bus.out, bus.valid);
            end
            step();
        end
        n_tests++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rstmid_readback_done got=%b exp=1", bus.done); end
        step();
    endtask

`ifdef REG_FILE_READER_PARITY_EN
    task automatic test_parity();
        write_reg(3'd0, 16'h0007);
        write_reg(3'd1, 16'h0003);
        bus.raddr = 3'd0; bus.len = 4'd2; bus.ready = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_tests++;
        if (bus.out !== 16'h0007 || bus.parity !== 1'b1) begin
            n_fail++; $display("FAIL parity_odd got o=%0h p=%b exp o=7 p=1", bus.out, bus.parity);
        end
        step();
        n_tests++;
        if (bus.parity !== 1'b1) begin n_fail++; $display("FAIL parity_hold got=%b exp=1", bus.parity); end
        bus.ready = 1'b1;
        step();
        n_tests++;
        if (bus.out !== 16'h0003 || bus.parity !== 1'b0) begin
            n_fail++; $display("FAIL parity_even got o=%0h p=%b exp o=3 p=0", bus.out, bus.parity);
        end
        step();
        step();
    endtask
`endif

    initial begin
        bus.load = 1'b0; bus.waddr = '0; bus.d = '0;
        bus.start = 1'b0; bus.raddr = '0; bus.len = '0; bus.ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_len_edges();
        test_start_busy();
        test_write_during();
        test_reset_mid();
`ifdef REG_FILE_READER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
